// File: rtl/fb_flip_ctrl_pkg.sv
// fb_flip_pkg: CSR map, bit positions and clear-engine states
// shared by the page-flip controller and its interfaces.
package fb_flip_pkg;

  localparam int CSR_AW = 3;

  localparam logic [CSR_AW-1:0] CSR_CTRL   = 3'd0;
  localparam logic [CSR_AW-1:0] CSR_STATUS = 3'd1;
  localparam logic [CSR_AW-1:0] CSR_FB0    = 3'd2;
  localparam logic [CSR_AW-1:0] CSR_FB1    = 3'd3;
  localparam logic [CSR_AW-1:0] CSR_COLOR  = 3'd4;

  localparam int CTRL_SWAP   = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_PEND  = 0;
  localparam int ST_BUSY  = 1;
  localparam int ST_IRQ   = 2;
  localparam int ST_FRONT = 3;

  typedef enum logic {
    IDLE,
    BURST
  } clear_state_t;

endpackage

// File: rtl/fb_flip_ctrl_if.sv
// Avalon-MM bundles: CSR slave port and clear-engine
// burst write master port.
interface fb_avs_if;
  import fb_flip_pkg::*;

  logic [CSR_AW-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;

  modport master (
    output avs_address, avs_read,
    output avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read,
    input  avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

interface fb_avm_if;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_burstcount;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_write,
    output avm_writedata, avm_burstcount,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_write,
    input  avm_writedata, avm_burstcount,
    output avm_waitrequest
  );
endinterface

// File: rtl/fb_flip_ctrl_vsync.sv
// vsync_edge_sync: two-flop synchroniser for the async vsync
// plus a one-cycle pulse on its falling edge.
module vsync_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic fall
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign fall = s3_q & ~s2_q;

endmodule

// File: rtl/fb_flip_ctrl.sv
// fb_flip_ctrl: double-buffer page flip on vsync, CSR regfile,
// IRQ on flip and a burst clear engine for the back buffer.
module fb_flip_ctrl
  import fb_flip_pkg::*;
#(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int BPP_BYTES = 2,
  parameter int BURST_LEN = 8
) (
  input  logic        clk,
  input  logic        reset,
  fb_avs_if.slave     avs,
  fb_avm_if.master    avm,
  input  logic        vga_vs,
  output logic [31:0] frame_buffer_ptr,
  output logic        irq
);

  localparam int FB_WORDS = H_RES * V_RES * BPP_BYTES / 4;
  localparam int WW = $clog2(FB_WORDS);
  localparam logic [WW-1:0] LAST_WORD = WW'(FB_WORDS - 1);
  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);
  localparam logic [31:0] STEP = 32'(BURST_LEN * 4);

  if ((FB_WORDS % BURST_LEN) != 0 || BURST_LEN > 15) begin : g_bad_cfg
    $error("FB_WORDS must be a multiple of BURST_LEN (<=15)");
  end

  logic vs_fall, busy, flip;
  logic wr_ctrl, wr_stat, swap_req, clr_req;
  logic irq_en_q, irq_en_d, pend_q, pend_d;
  logic irqf_q, irqf_d, front_q, front_d;
  logic [15:0] vcnt_q, vcnt_d;
  logic [26:0] fb0_q, fb0_d, fb1_q, fb1_d;
  logic [31:0] color_q, color_d;
  logic [31:0] rdata_q, rdata_d, ptr_q, ptr_d;
  clear_state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, cc_q, cc_d;
  logic [3:0] beat_q, beat_d;
  logic [WW-1:0] word_q, word_d;

  vsync_edge_sync u_vs (
    .clk      (clk),
    .reset    (reset),
    .async_in (vga_vs),
    .fall     (vs_fall)
  );

  assign wr_ctrl  = avs.avs_write && avs.avs_address == CSR_CTRL;
  assign wr_stat  = avs.avs_write && avs.avs_address == CSR_STATUS;
  assign swap_req = wr_ctrl && avs.avs_writedata[CTRL_SWAP];
  assign clr_req  = wr_ctrl && avs.avs_writedata[CTRL_CLEAR];
  assign busy     = (state_q == BURST);
  // Flip decision uses pending as it stood before this cycle.
  assign flip     = vs_fall && pend_q && !busy;

  always_comb begin
    irq_en_d = irq_en_q;
    pend_d   = pend_q;
    irqf_d   = irqf_q;
    front_d  = front_q;
    vcnt_d   = vcnt_q;
    fb0_d    = fb0_q;
    fb1_d    = fb1_q;
    color_d  = color_q;
    if (wr_ctrl)
      irq_en_d = avs.avs_writedata[CTRL_IRQ_EN];
    if (swap_req)
      pend_d = 1'b1;
    if (wr_stat && avs.avs_writedata[ST_IRQ])
      irqf_d = 1'b0;
    if (vs_fall)
      vcnt_d = vcnt_q + 16'd1;
    if (flip) begin
      pend_d  = 1'b0;
      irqf_d  = 1'b1;
      front_d = ~front_q;
    end
    if (avs.avs_write) begin
      unique case (1'b1)
        avs.avs_address == CSR_FB0:
          fb0_d = avs.avs_writedata[31:5];
        avs.avs_address == CSR_FB1:
          fb1_d = avs.avs_writedata[31:5];
        avs.avs_address == CSR_COLOR:
          color_d = avs.avs_writedata;
        default: ;
      endcase
    end
    ptr_d = front_q ? {fb1_q, 5'd0} : {fb0_q, 5'd0};
  end

  always_comb begin
    rdata_d = '0;
    if (avs.avs_read) begin
      case (avs.avs_address)
        CSR_CTRL:   rdata_d[CTRL_IRQ_EN] = irq_en_q;
        CSR_STATUS: rdata_d = {vcnt_q, 12'd0, front_q,
                               irqf_q, busy, pend_q};
        CSR_FB0:    rdata_d = {fb0_q, 5'd0};
        CSR_FB1:    rdata_d = {fb1_q, 5'd0};
        CSR_COLOR:  rdata_d = color_q;
        default:    rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cc_d    = cc_q;
    beat_d  = beat_q;
    word_d  = word_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = BURST;
          addr_d  = front_q ? {fb0_q, 5'd0} : {fb1_q, 5'd0};
          cc_d    = color_q;
          beat_d  = '0;
          word_d  = '0;
        end
      end
      BURST: begin
        if (!avm.avm_waitrequest) begin
          word_d = word_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            addr_d = addr_q + STEP;
          end else begin
            beat_d = beat_q + 4'd1;
          end
          if (word_q == LAST_WORD)
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      pend_q   <= 1'b0;
      irqf_q   <= 1'b0;
      front_q  <= 1'b0;
      vcnt_q   <= '0;
      fb0_q    <= '0;
      fb1_q    <= '0;
      color_q  <= '0;
      rdata_q  <= '0;
      ptr_q    <= '0;
      state_q  <= IDLE;
      addr_q   <= '0;
      cc_q     <= '0;
      beat_q   <= '0;
      word_q   <= '0;
    end else begin
      irq_en_q <= irq_en_d;
      pend_q   <= pend_d;
      irqf_q   <= irqf_d;
      front_q  <= front_d;
      vcnt_q   <= vcnt_d;
      fb0_q    <= fb0_d;
      fb1_q    <= fb1_d;
      color_q  <= color_d;
      rdata_q  <= rdata_d;
      ptr_q    <= ptr_d;
      state_q  <= state_d;
      addr_q   <= addr_d;
      cc_q     <= cc_d;
      beat_q   <= beat_d;
      word_q   <= word_d;
    end
  end

  assign avs.avs_readdata   = rdata_q;
  assign avm.avm_write      = busy;
  assign avm.avm_address    = addr_q;
  assign avm.avm_writedata  = cc_q;
  assign avm.avm_burstcount = 4'(BURST_LEN);
  assign frame_buffer_ptr   = ptr_q;
  assign irq                = irqf_q & irq_en_q;

endmodule

// File: tb/tb_fb_flip_ctrl.sv
// Bench for fb_flip_ctrl: directed + randomized steps checked
// against a register-level model and a beat scoreboard.
module tb_fb_flip_ctrl;
  import fb_flip_pkg::*;

  localparam int H = 64;
  localparam int V = 16;
  localparam int BPP = 2;
  localparam int BL = 8;
  localparam int FBW = H * V * BPP / 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic vga_vs = 1'b1;
  logic [31:0] frame_buffer_ptr;
  logic irq;

  fb_avs_if csr ();
  fb_avm_if mem ();

  fb_flip_ctrl #(
    .H_RES(H), .V_RES(V), .BPP_BYTES(BPP), .BURST_LEN(BL)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .avs              (csr),
    .avm              (mem),
    .vga_vs           (vga_vs),
    .frame_buffer_ptr (frame_buffer_ptr),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        m_irq_en, m_pend, m_irqf, m_front, m_busy;
  logic [15:0] m_vcnt;
  logic [31:0] m_fb0, m_fb1, m_color;

  logic        mon_en = 1'b1;
  logic [31:0] mon_base, mon_color, first_addr, last_addr;
  int          beats, bursts, beat_errs;

  initial begin
    mon_base = '0; mon_color = '0;
    first_addr = '0; last_addr = '0;
    beats = 0; bursts = 0; beat_errs = 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_ptr();
    return m_front ? m_fb1 : m_fb0;
  endfunction

  function automatic logic [31:0] exp_status();
    return {m_vcnt, 12'd0, m_front, m_irqf, m_busy, m_pend};
  endfunction

  task automatic model_reset();
    m_irq_en = 0; m_pend = 0; m_irqf = 0; m_front = 0;
    m_busy = 0; m_vcnt = 0;
    m_fb0 = 0; m_fb1 = 0; m_color = 0;
  endtask

  // Clear engine scoreboard: random stalls, every accepted beat checked.
  always @(negedge clk) begin
    mem.avm_waitrequest = ($urandom_range(0, 3) == 0);
    if (mon_en && !reset && mem.avm_write && !mem.avm_waitrequest) begin
      if (mem.avm_address !== mon_base + 32'((beats / BL) * BL * 4) ||
          mem.avm_writedata !== mon_color ||
          mem.avm_burstcount !== 4'(BL))
        beat_errs++;
      if (beats % BL == 0) bursts++;
      if (beats == 0) first_addr = mem.avm_address;
      last_addr = mem.avm_address;
      beats++;
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    case (a)
      CSR_CTRL: begin
        m_irq_en = d[2];
        if (d[0]) m_pend = 1;
        if (d[1] && !m_busy) begin
          m_busy = 1;
          mon_base = m_front ? m_fb0 : m_fb1;
          mon_color = m_color;
          beats = 0; bursts = 0; beat_errs = 0;
        end
      end
      CSR_STATUS: if (d[2]) m_irqf = 0;
      CSR_FB0: m_fb0 = d & ~32'h1F;
      CSR_FB1: m_fb1 = d & ~32'h1F;
      CSR_COLOR: m_color = d;
      default: ;
    endcase
    @(negedge clk);
    csr.avs_write = 1; csr.avs_address = a; csr.avs_writedata = d;
    @(negedge clk);
    csr.avs_write = 0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    csr.avs_read = 1; csr.avs_address = a;
    @(negedge clk);
    csr.avs_read = 0;
    d = csr.avs_readdata;
  endtask

  // Pointer must hold until the 3rd edge after vsync is seen low.
  task automatic vsync();
    logic [31:0] old_ptr;
    old_ptr = exp_ptr();
    @(negedge clk) vga_vs = 0;
    repeat (3) @(negedge clk);
    chk("vs_ptr_hold", frame_buffer_ptr, old_ptr);
    m_vcnt++;
    if (m_pend && !m_busy) begin
      m_front = ~m_front; m_pend = 0; m_irqf = 1;
    end
    @(negedge clk);
    chk("vs_ptr_new", frame_buffer_ptr, exp_ptr());
    chk("vs_irq", {31'd0, irq}, {31'd0, m_irqf & m_irq_en});
    repeat ($urandom_range(1, 4)) @(negedge clk);
    vga_vs = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_clear();
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      rd(CSR_STATUS, s);
      n++;
    end while (s[ST_BUSY] && n < 4000);
    m_busy = 0;
    chk("clear_done", {31'd0, s[ST_BUSY]}, 32'd0);
    repeat (4) @(negedge clk);
    chk("clr_beats", 32'(beats), 32'(FBW));
    chk("clr_bursts", 32'(bursts), 32'(FBW / BL));
    chk("clr_beat_errs", 32'(beat_errs), 32'd0);
    chk("clr_first", first_addr, mon_base);
    chk("clr_last", last_addr, mon_base + 32'((FBW / BL - 1) * BL * 4));
  endtask

  initial begin
    logic [31:0] d;
    csr.avs_read = 0; csr.avs_write = 0;
    csr.avs_address = '0; csr.avs_writedata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 0;

    // Reset state
    chk("rst_ptr", frame_buffer_ptr, 32'd0);
    chk("rst_avm_write", {31'd0, mem.avm_write}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      chk("rst_csr", d, 32'd0);
    end

    // Clear of back buffer FB1 while front is FB0
    wr(CSR_FB1, 32'h0009_6000);
    wr(CSR_COLOR, 32'h1234_5678);
    wr(CSR_CTRL, 32'h2);
    rd(CSR_STATUS, d);
    chk("clr_busy", d, exp_status());
    wait_clear();
    chk("t3_first", first_addr, 32'h0009_6000);
    chk("t3_last", last_addr, 32'h0009_6000 + 32'((FBW - BL) * 4));

    // Flip with IRQ, then W1C
    wr(CSR_CTRL, 32'h5);
    vsync();
    chk("t2_ptr", frame_buffer_ptr, 32'h0009_6000);
    chk("t2_irq", {31'd0, irq}, 32'd1);
    wr(CSR_STATUS, 32'h4);
    chk("t2_irq_w1c", {31'd0, irq}, 32'd0);

    // Swap held off while clearing; base/color edits are deferred
    wr(CSR_FB0, 32'h0020_0000);
    wr(CSR_COLOR, $urandom);
    wr(CSR_CTRL, {29'd0, m_irq_en, 2'b10});
    wr(CSR_FB0, $urandom);
    wr(CSR_COLOR, $urandom);
    wr(CSR_CTRL, {29'd0, m_irq_en, 2'b01});
    repeat (3) vsync();
    rd(CSR_STATUS, d);
    chk("t4_status_mid", d, exp_status());
    wait_clear();
    chk("t4_first", first_addr, 32'h0020_0000);
    vsync();
    rd(CSR_STATUS, d);
    chk("t4_status_flip", d, exp_status());

    // Swap request landing in the vs_edge cycle flips one edge later
    @(negedge clk) vga_vs = 0;
    repeat (2) @(negedge clk);
    csr.avs_write = 1; csr.avs_address = CSR_CTRL;
    csr.avs_writedata = {29'd0, m_irq_en, 2'b01};
    @(negedge clk);
    csr.avs_write = 0;
    m_vcnt++; m_pend = 1;
    @(negedge clk);
    chk("t5_noflip", frame_buffer_ptr, exp_ptr());
    rd(CSR_STATUS, d);
    chk("t5_status", d, exp_status());
    vga_vs = 1;
    repeat (4) @(negedge clk);
    vsync();
    rd(CSR_STATUS, d);
    chk("t5_status_flip", d, exp_status());

    // Randomized register traffic around vsyncs
    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(0, 1) == 1) wr(CSR_FB0, $urandom);
      if ($urandom_range(0, 1) == 1) wr(CSR_FB1, $urandom);
      if ($urandom_range(0, 1) == 1)
        wr(CSR_CTRL, {29'd0, 1'($urandom_range(0, 1)), 1'b0,
                      1'($urandom_range(0, 1))});
      if ($urandom_range(0, 2) == 0) wr(CSR_STATUS, 32'h4);
      vsync();
      rd(CSR_STATUS, d);
      chk("rnd_status", d, exp_status());
      rd(CSR_FB0, d);
      chk("rnd_fb0", d, m_fb0);
      rd(CSR_FB1, d);
      chk("rnd_fb1", d, m_fb1);
      rd(CSR_CTRL, d);
      chk("rnd_ctrl", d, {29'd0, m_irq_en, 2'b00});
    end

    // Reset in the middle of a burst
    mon_en = 0;
    wr(CSR_CTRL, 32'h2);
    repeat (5) @(negedge clk);
    chk("t6_writing", {31'd0, mem.avm_write}, 32'd1);
    #2 reset = 1;
    #1 chk("t6_async", {31'd0, mem.avm_write}, 32'd0);
    @(negedge clk);
    @(negedge clk) reset = 0;
    model_reset();
    rd(CSR_STATUS, d);
    chk("t6_status", d, 32'd0);
    chk("t6_ptr", frame_buffer_ptr, 32'd0);
    chk("t6_irq", {31'd0, irq}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: timeout reached, expected finish earlier");
    $fatal(1, "timeout");
  end

endmodule
